// File: rtl/sd_file_unloader_pkg.sv
// Shared definitions for the memory-dump unloader: FSM encodings, default image length,
// and the byte-lane selector used when unpacking a word.
package sd_file_unloader_pkg;

  // Image length shared with the boot loader so both agree on the dump size.
  localparam logic [31:0] BIN_SIZE = 32'd4096;

  localparam logic [1:0] LAST_LANE = 2'd3;

  typedef enum logic [2:0] {
    SU_IDLE = 3'd0,
    SU_REQ  = 3'd1,
    SU_ACK  = 3'd2,
    SU_WAIT = 3'd3,
    SU_EMIT = 3'd4,
    SU_FIN  = 3'd5
  } su_state_t;

  // Little-endian lane pick: lane 0 is word[7:0].
  function automatic logic [7:0] word_lane(input logic [31:0] word, input logic [1:0] lane);
    word_lane = word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/sd_file_unloader_word_to_bytes.sv
// Holds one fetched memory word and presents it LSB-first, one byte lane per sink transfer.
module sd_file_unloader_word_to_bytes
  import sd_file_unloader_pkg::*;
(
  input  logic        clk27mhz,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] data,
  input  logic        advance,
  input  logic        final_byte,
  output logic [7:0]  lane_byte,
  output logic        last_lane,
  output logic        outen
);

  logic [31:0] word_q;
  logic [1:0]  lane_q;

  always_ff @(posedge clk27mhz or posedge reset) begin
    if (reset) begin
      word_q    <= '0;
      lane_q    <= '0;
      lane_byte <= '0;
      outen     <= 1'b0;
    end else if (load) begin
      word_q    <= data;
      lane_q    <= 2'd0;
      lane_byte <= word_lane(data, 2'd0);
      outen     <= 1'b1;
    end else if (advance && outen) begin
      lane_q    <= lane_q + 2'd1;
      lane_byte <= word_lane(word_q, lane_q + 2'd1);
      // The word is exhausted either at its top lane or at the image tail.
      if (final_byte || lane_q == LAST_LANE) begin
        outen <= 1'b0;
      end
    end
  end

  assign last_lane = (lane_q == LAST_LANE);

endmodule

// File: rtl/sd_file_unloader.sv
// Dumps a memory image through the controller idle/ack read port as a little-endian
// byte stream for a byte sink (SD file writer or UART TX).
module sd_file_unloader
  import sd_file_unloader_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [31:0]        DUMP_SIZE = BIN_SIZE
) (
  input  logic              clk27mhz,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        w_ctrl_state,
  output logic              RE,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       RDATA,
  input  logic              RVALID,
  output logic [7:0]        outbyte,
  output logic              outen,
  input  logic              outready,
  output logic              BUSY,
  output logic              DONE,
  output su_state_t         dbg_state
);

  // Handshakes: a read is requested by raising RE while the controller is idle
  // (w_ctrl_state==0) and is accepted once the controller leaves idle; the word then
  // arrives on a single-cycle RVALID. A byte moves to the sink on any cycle with
  // outen & outready, and outen/outbyte hold steady while outready is low.

  su_state_t   state;
  logic [31:0] cnt;
  logic        xfer;
  logic        load;
  logic        final_byte;
  logic        last_lane;
  logic [7:0]  lane_byte;

  assign xfer       = (state == SU_EMIT) && outen && outready;
  assign load       = (state == SU_WAIT) && RVALID;
  assign final_byte = ((cnt + 32'd1) == DUMP_SIZE);
  assign outbyte    = lane_byte;
  assign dbg_state  = state;

  sd_file_unloader_word_to_bytes u_word_to_bytes (
    .clk27mhz   (clk27mhz),
    .reset      (reset),
    .load       (load),
    .data       (RDATA),
    .advance    (xfer),
    .final_byte (final_byte),
    .lane_byte  (lane_byte),
    .last_lane  (last_lane),
    .outen      (outen)
  );

  always_ff @(posedge clk27mhz or posedge reset) begin
    if (reset) begin
      state <= SU_IDLE;
      RE    <= 1'b0;
      ADDR  <= BASE_ADDR;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        SU_IDLE: begin
          if (start) begin
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
            cnt   <= '0;
            ADDR  <= BASE_ADDR;
            state <= (DUMP_SIZE == 32'd0) ? SU_FIN : SU_REQ;
          end
        end
        SU_REQ: begin
          if (w_ctrl_state == 8'd0) begin
            RE    <= 1'b1;
            state <= SU_ACK;
          end
        end
        SU_ACK: begin
          if (w_ctrl_state != 8'd0) begin
            RE    <= 1'b0;
            state <= SU_WAIT;
          end
        end
        SU_WAIT: begin
          if (RVALID) begin
            state <= SU_EMIT;
          end
        end
        SU_EMIT: begin
          if (xfer) begin
            cnt <= cnt + 32'd1;
            if (final_byte) begin
              state <= SU_FIN;
            end else if (last_lane) begin
              ADDR  <= ADDR + ADDR_W'(4);
              state <= SU_REQ;
            end
          end
        end
        SU_FIN: begin
          RE    <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= SU_IDLE;
        end
        default: begin
          state <= SU_IDLE;
        end
      endcase
    end
  end

endmodule
